// File: rtl/resource_arbiter_if.sv
// resource_arbiter_if: requester/arbiter handshake bundle
//   req[3:0]      requester -> arbiter, level request lines
//   done          requester -> arbiter, release pulse from current owner
//   grant[3:0]    arbiter -> requester, registered one-hot grant
//   grant_id[1:0] arbiter -> requester, encoded owner index (datapath mux select)
//   busy          arbiter -> requester, resource currently owned
//   none_req      arbiter -> requester, combinational req == 0
//   timeout       arbiter -> requester, one-cycle forced-release pulse
interface resource_arbiter_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       none_req;
  logic       timeout;
  modport master(output req, done, input grant, grant_id, busy, none_req, timeout);
  modport slave(input req, done, output grant, grant_id, busy, none_req, timeout);
endinterface

// File: rtl/resource_arbiter.sv
// resource_arbiter: grants one shared resource to one of 4 requesters, held until release
//   clk  in  system clock, rising edge
//   rst  in  asynchronous active-high reset
//   arb  slave modport of resource_arbiter_if (req/done in; grant/grant_id/busy/none_req/timeout out)
//   HOLD_MAX: max cycles a grant is held before forced release; CNT_W: hold counter width
//   ROUND_ROBIN_EN: when defined, rotating priority starting after the last owner;
//   otherwise fixed priority req[3] > req[2] > req[1] > req[0]
module resource_arbiter #(
  parameter int CNT_W    = 4,
  parameter int HOLD_MAX = 15
) (
  input logic               clk,
  input logic               rst,
  resource_arbiter_if.slave arb
);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(HOLD_MAX - 1);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_GAP = 2'd2} state_t;
  state_t           r_state, w_state_nx;
  logic [3:0]       r_grant, w_grant_nx;
  logic [1:0]       r_id, w_id_nx;
  logic             r_busy, w_busy_nx;
  logic             r_timeout, w_timeout_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [1:0]       w_win;
  logic             w_held, w_to;
`ifdef ROUND_ROBIN_EN
  logic [1:0] r_last_id;
  logic [1:0] w_cand;
  // Scan from highest offset down so the nearest requester after last_id wins.
  always_comb begin
    w_win  = 2'd0;
    w_cand = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      w_cand = r_last_id + 2'(k + 1);
      if (arb.req[w_cand]) w_win = w_cand;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_last_id <= 2'b11;
    else if (r_state == S_IDLE && arb.req != 4'b0000) r_last_id <= w_win;
`else
  always_comb w_win = arb.req[3] ? 2'd3 : arb.req[2] ? 2'd2 : arb.req[1] ? 2'd1 : 2'd0;
`endif
  assign w_held = arb.req[r_id];
  assign w_to   = r_cnt == LP_LAST;
  always_comb begin
    w_state_nx   = S_IDLE;
    w_grant_nx   = 4'b0000;
    w_id_nx      = 2'b00;
    w_busy_nx    = 1'b0;
    w_timeout_nx = 1'b0;
    w_cnt_nx     = '0;
    case (r_state)
      S_IDLE:
        if (arb.req != 4'b0000) begin
          w_state_nx = S_BUSY;
          w_grant_nx = 4'b0001 << w_win;
          w_id_nx    = w_win;
          w_busy_nx  = 1'b1;
        end
      S_BUSY:
        if (arb.done || !w_held || w_to) begin
          w_state_nx   = S_GAP;
          w_timeout_nx = w_to && !arb.done && w_held;
        end else begin
          w_state_nx = S_BUSY;
          w_grant_nx = r_grant;
          w_id_nx    = r_id;
          w_busy_nx  = 1'b1;
          w_cnt_nx   = r_cnt + 1'b1;
        end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= S_IDLE;
      r_grant   <= 4'b0000;
      r_id      <= 2'b00;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_grant   <= w_grant_nx;
      r_id      <= w_id_nx;
      r_busy    <= w_busy_nx;
      r_timeout <= w_timeout_nx;
      r_cnt     <= w_cnt_nx;
    end
  assign arb.grant    = r_grant;
  assign arb.grant_id = r_id;
  assign arb.busy     = r_busy;
  assign arb.timeout  = r_timeout;
  assign arb.none_req = arb.req == 4'b0000;
endmodule

// File: tb/tb_resource_arbiter.sv
// tb_resource_arbiter: directed checks of the fixed-priority arbiter built with HOLD_MAX=4
module tb_resource_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  resource_arbiter_if arb ();
  resource_arbiter #(.CNT_W(4), .HOLD_MAX(4)) dut (.clk(clk), .rst(rst), .arb(arb));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] id, input logic b, input logic t);
    chk({tag, ".grant"}, arb.grant, g);
    chk({tag, ".grant_id"}, {2'b00, arb.grant_id}, {2'b00, id});
    chk({tag, ".busy"}, {3'b000, arb.busy}, {3'b000, b});
    chk({tag, ".timeout"}, {3'b000, arb.timeout}, {3'b000, t});
  endtask
  initial begin
    arb.req  = 4'b0000;
    arb.done = 1'b0;
    #3;
    chk_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    chk("reset.none_req", {3'b000, arb.none_req}, 4'd1);
    step();
    step();
    rst = 1'b0;
    arb.req = 4'b1011;
    chk("none_req_1011", {3'b000, arb.none_req}, 4'd0);
    step();
    chk_all("prio_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
    arb.done = 1'b1;
    step();
    chk_all("prio_done_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
    arb.done = 1'b0;
    step();
    chk_all("prio_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    chk_all("prio_regrant", 4'b1000, 2'd3, 1'b1, 1'b0);
    arb.req = 4'b0000;
    step();
    chk_all("prio_withdraw", 4'b0000, 2'd0, 1'b0, 1'b0);
    chk("none_req_0", {3'b000, arb.none_req}, 4'd1);
    step();
    arb.req = 4'b0001;
    step();
    chk_all("nopre_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    arb.req = 4'b1001;
    step();
    chk_all("nopre_hold1", 4'b0001, 2'd0, 1'b1, 1'b0);
    step();
    chk_all("nopre_hold2", 4'b0001, 2'd0, 1'b1, 1'b0);
    arb.done = 1'b1;
    step();
    chk_all("nopre_gap", 4'b0000, 2'd0, 1'b0, 1'b0);
    arb.done = 1'b0;
    step();
    chk("nopre_idle", arb.grant, 4'b0000);
    step();
    chk_all("nopre_winner3", 4'b1000, 2'd3, 1'b1, 1'b0);
    arb.req = 4'b0000;
    step();
    step();
    arb.req = 4'b0010;
    step();
    chk_all("to_c0", 4'b0010, 2'd1, 1'b1, 1'b0);
    step();
    chk_all("to_c1", 4'b0010, 2'd1, 1'b1, 1'b0);
    step();
    chk_all("to_c2", 4'b0010, 2'd1, 1'b1, 1'b0);
    step();
    chk_all("to_c3", 4'b0010, 2'd1, 1'b1, 1'b0);
    step();
    chk_all("to_pulse", 4'b0000, 2'd0, 1'b0, 1'b1);
    step();
    chk_all("to_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    chk_all("to_regrant", 4'b0010, 2'd1, 1'b1, 1'b0);
    step();
    step();
    step();
    chk("to_c3_again", arb.grant, 4'b0010);
    arb.done = 1'b1;
    step();
    chk_all("done_and_to", 4'b0000, 2'd0, 1'b0, 1'b0);
    arb.done = 1'b0;
    arb.req  = 4'b0000;
    step();
    arb.req = 4'b0100;
    step();
    chk_all("wd_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    arb.req = 4'b0000;
    step();
    chk_all("wd_release", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    arb.done = 1'b1;
    step();
    chk_all("done_in_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    arb.req = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      step();
      chk_all("all_req_grant", 4'b1000, 2'd3, 1'b1, 1'b0);
      step();
      chk("all_req_gap", arb.grant, 4'b0000);
      step();
    end
    arb.done = 1'b0;
    arb.req  = 4'b0000;
    step();
    step();
    arb.req = 4'b0100;
    step();
    chk("rst_pre", arb.grant, 4'b0100);
    #2;
    rst = 1'b1;
    #1;
    chk_all("rst_async", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    chk("rst_held", arb.grant, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk_all("rst_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
